// File: rtl/commit_tracker_pkg.sv
// Shared constants and helpers for the retirement buffer: trap opcode,
// commit-record field widths and record packing order.
package commit_tracker_pkg;

  localparam int XLEN_DEF     = 64;
  localparam int COMMIT_W_DEF = 2;
  localparam int DEPTH_DEF    = 8;

  localparam logic [6:0] TRAP_OPCODE = 7'h6b;

  localparam int INST_W  = 32;
  localparam int WDEST_W = 5;

  // Record layout, MSB to LSB: {skip, wen, wdest, wdata, inst, pc}
  function automatic int rec_width(input int xlen);
    return 1 + 1 + WDEST_W + xlen + INST_W + xlen;
  endfunction

  function automatic logic is_trap(input logic [INST_W-1:0] inst);
    return inst[6:0] == TRAP_OPCODE;
  endfunction

endpackage

// File: rtl/commit_tracker_if.sv
// Writeback-side intake and Difftest-side drain bundle of the commit tracker.
interface commit_tracker_if #(
  parameter int XLEN     = 64,
  parameter int COMMIT_W = 2
);
  logic [COMMIT_W-1:0]        in_valid;
  logic [COMMIT_W*XLEN-1:0]   in_pc;
  logic [COMMIT_W*32-1:0]     in_inst;
  logic [COMMIT_W-1:0]        in_wen;
  logic [COMMIT_W*5-1:0]      in_wdest;
  logic [COMMIT_W*XLEN-1:0]   in_wdata;
  logic [COMMIT_W-1:0]        in_skip;
  logic [XLEN-1:0]            in_a0;
  logic                       in_ready;

  logic [COMMIT_W-1:0]        out_valid;
  logic [COMMIT_W*XLEN-1:0]   out_pc;
  logic [COMMIT_W*32-1:0]     out_inst;
  logic [COMMIT_W-1:0]        out_wen;
  logic [COMMIT_W*5-1:0]      out_wdest;
  logic [COMMIT_W*XLEN-1:0]   out_wdata;
  logic [COMMIT_W-1:0]        out_skip;
  logic                       out_ready;

  // master: writeback producer that also consumes the drained stream
  modport master (
    output in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, in_a0, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_wen, out_wdest, out_wdata, out_skip
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_wen, in_wdest, in_wdata, in_skip, in_a0, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_wen, out_wdest, out_wdata, out_skip
  );
endinterface

// File: rtl/commit_fifo.sv
// Multi-write / multi-read circular buffer: up to COMMIT_W pushes and pops
// per cycle, head entries shown first-word fall-through.
module commit_fifo #(
  parameter  int DEPTH    = 8,
  parameter  int COMMIT_W = 2,
  parameter  int REC_W    = 167,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int LANE_W   = $clog2(COMMIT_W + 1)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [LANE_W-1:0]                  push_n,
  input  logic [COMMIT_W-1:0][REC_W-1:0]     push_rec,
  input  logic [LANE_W-1:0]                  pop_n,
  output logic [CNT_W-1:0]                   count,
  output logic [COMMIT_W-1:0][REC_W-1:0]     head_rec
);

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  // NOTE: payload storage has no reset; validity is carried by count alone,
  // which keeps the array a plain RAM-style structure.
  always_ff @(posedge clock) begin
    for (int i = 0; i < COMMIT_W; i++) begin
      if (i < int'(push_n)) mem[wr_ptr + PTR_W'(i)] <= push_rec[i];
    end
  end

  for (genvar j = 0; j < COMMIT_W; j++) begin : g_head
    assign head_rec[j] = mem[rd_ptr + PTR_W'(j)];
  end

endmodule

// File: rtl/commit_tracker.sv
// Retirement buffer between writeback and Difftest: queues retired lanes,
// detects the trap instruction and keeps the cycle/instruction counters.
module commit_tracker
  import commit_tracker_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int COMMIT_W = COMMIT_W_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  commit_tracker_if.slave    bus,
  output logic               trap_valid,
  output logic [7:0]         trap_code,
  output logic [XLEN-1:0]    trap_pc,
  output logic [63:0]        cycle_cnt,
  output logic [63:0]        instr_cnt,
  output logic               overflow_err
);

  localparam int REC_W     = rec_width(XLEN);
  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int LANE_W    = $clog2(COMMIT_W + 1);
  localparam int INST_LSB  = XLEN;
  localparam int WDATA_LSB = XLEN + INST_W;
  localparam int WDEST_LSB = 2 * XLEN + INST_W;
  localparam int WEN_BIT   = WDEST_LSB + WDEST_W;
  localparam int SKIP_BIT  = WEN_BIT + 1;

  logic                           trap_seen;
  logic [CNT_W-1:0]               count;
  logic [CNT_W-1:0]               free_slots;
  logic [LANE_W-1:0]              n_in;
  logic [LANE_W-1:0]              n_out;
  logic [COMMIT_W-1:0][REC_W-1:0] push_rec;
  logic [COMMIT_W-1:0][REC_W-1:0] head_rec;
  logic                           trap_hit;
  logic [XLEN-1:0]                trap_hit_pc;
  logic                           trap_drain;

  // Registered state only: a drain this cycle never opens intake this cycle.
  assign free_slots   = CNT_W'(DEPTH) - count;
  assign bus.in_ready = (free_slots >= CNT_W'(COMMIT_W)) && !trap_seen;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred on any path.
  always_comb begin
    n_in        = '0;
    push_rec    = '0;
    trap_hit    = 1'b0;
    trap_hit_pc = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      push_rec[i] = {bus.in_skip[i], bus.in_wen[i],
                     bus.in_wdest[i*WDEST_W +: WDEST_W],
                     bus.in_wdata[i*XLEN +: XLEN],
                     bus.in_inst[i*INST_W +: INST_W],
                     bus.in_pc[i*XLEN +: XLEN]};
      // Lanes above the first trap lane are dropped along with the rest of intake.
      if (bus.in_ready && bus.in_valid[i] && !trap_hit) begin
        n_in = n_in + LANE_W'(1);
        if (is_trap(bus.in_inst[i*INST_W +: INST_W])) begin
          trap_hit    = 1'b1;
          trap_hit_pc = bus.in_pc[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    n_out      = '0;
    trap_drain = 1'b0;
    if (bus.out_ready) begin
      n_out = (count >= CNT_W'(COMMIT_W)) ? LANE_W'(COMMIT_W) : LANE_W'(count);
    end
    for (int j = 0; j < COMMIT_W; j++) begin
      if (j < int'(n_out) && is_trap(head_rec[j][INST_LSB +: INST_W])) trap_drain = 1'b1;
    end
  end

  commit_fifo #(
    .DEPTH    (DEPTH),
    .COMMIT_W (COMMIT_W),
    .REC_W    (REC_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_n   (n_in),
    .push_rec (push_rec),
    .pop_n    (n_out),
    .count    (count),
    .head_rec (head_rec)
  );

  for (genvar j = 0; j < COMMIT_W; j++) begin : g_out
    assign bus.out_valid[j]                      = (int'(count) > j);
    assign bus.out_pc[j*XLEN +: XLEN]            = head_rec[j][0 +: XLEN];
    assign bus.out_inst[j*INST_W +: INST_W]      = head_rec[j][INST_LSB +: INST_W];
    assign bus.out_wdata[j*XLEN +: XLEN]         = head_rec[j][WDATA_LSB +: XLEN];
    assign bus.out_wdest[j*WDEST_W +: WDEST_W]   = head_rec[j][WDEST_LSB +: WDEST_W];
    assign bus.out_wen[j]                        = head_rec[j][WEN_BIT];
    assign bus.out_skip[j]                       = head_rec[j][SKIP_BIT];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trap_seen    <= 1'b0;
      trap_code    <= '0;
      trap_pc      <= '0;
      trap_valid   <= 1'b0;
      cycle_cnt    <= '0;
      instr_cnt    <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (trap_hit) begin
        trap_seen <= 1'b1;
        trap_code <= bus.in_a0[7:0];
        trap_pc   <= trap_hit_pc;
      end
      if (trap_drain) trap_valid <= 1'b1;
      if (!trap_valid) cycle_cnt <= cycle_cnt + 64'd1;
      instr_cnt <= instr_cnt + 64'(n_out);
      if ((|bus.in_valid) && !bus.in_ready) overflow_err <= 1'b1;
    end
  end

endmodule

// File: doc/commit_tracker.md
Name: commit_tracker

Overview:
- Parametrised, multi-lane retirement buffer between the core's writeback stage and the Difftest commit, trap and counter interfaces.
- Accepts up to COMMIT_W retired instructions per cycle and queues them in a DEPTH-entry circular buffer.
- Drains up to COMMIT_W entries per cycle under a ready handshake.
- Detects the trap instruction, freezes intake after it, and maintains the cycle and instruction counters; the previous single-commit, unbuffered scheme did none of this.

Parameters:
- XLEN, 64, register and PC data width.
- COMMIT_W, 2, number of input lanes and number of output lanes.
- DEPTH, 8, buffer entries; must be a power of two and at least COMMIT_W.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  COMMIT_W  per-lane retire valid; lanes packed from lane 0 (lane i valid implies lanes 0..i-1 valid).
- in_pc  in  COMMIT_W*XLEN  per-lane PC.
- in_inst  in  COMMIT_W*32  per-lane instruction word.
- in_wen  in  COMMIT_W  per-lane rd write enable.
- in_wdest  in  COMMIT_W*5  per-lane rd index.
- in_wdata  in  COMMIT_W*XLEN  per-lane rd data.
- in_skip  in  COMMIT_W  per-lane Difftest skip (CSR and putch instructions).
- in_a0  in  XLEN  architectural x10 value in the same cycle; supplies the trap code.
- in_ready  out  1  buffer can accept a full COMMIT_W-lane group this cycle.
- out_valid  out  COMMIT_W  per-lane drain valid; packed from lane 0.
- out_pc, out_inst, out_wen, out_wdest, out_wdata, out_skip  out  per lane, same widths as the inputs  head entries.
- out_ready  in  1  consumer accepts all currently valid out lanes.
- trap_valid  out  1  trap instruction has drained; sticky.
- trap_code  out  8  in_a0[7:0] captured at trap enqueue.
- trap_pc  out  XLEN  PC of the trap instruction.
- cycle_cnt  out  64  cycles since reset, frozen at trap.
- instr_cnt  out  64  entries drained, trap entry included.
- overflow_err  out  1  sticky; set when in_valid is nonzero while in_ready=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - Pointers, count, counters, trap_valid, trap_code, trap_pc, overflow_err and the trap_seen flag clear to 0.
  - in_ready=1 (when DEPTH>=COMMIT_W); out_valid=0.
  - Reset mid-operation discards all entries. Entry payload storage is not reset.
- Enqueue:
  - n_in = popcount(in_valid & in_ready replicated across lanes).
  - Lane i is written to entry (wr_ptr+i) mod DEPTH; wr_ptr += n_in, wrapping modulo DEPTH.
  - Entries are visible at the outputs the cycle after the write edge (1-cycle latency).
- in_ready = ((DEPTH - count) >= COMMIT_W) & ~trap_seen. It is computed from registered state only, with no combinational path from out_ready.
- Trap:
  - A lane whose in_inst[6:0]==7'h6b is a trap lane. Only the lowest-indexed trap lane is enqueued; higher lanes in that cycle are discarded.
  - At that edge: trap_seen=1, trap_code=in_a0[7:0], trap_pc=that lane's PC. in_ready stays 0 until reset.
- Dequeue (first-word fall-through):
  - out lane j shows entry (rd_ptr+j) mod DEPTH; out_valid[j] = (j < count).
  - When out_ready=1: n_out = min(count, COMMIT_W); rd_ptr += n_out, wrapping modulo DEPTH.
  - When out_ready=0: the outputs hold steady.
- Simultaneous enqueue and dequeue: count_next = count + n_in - n_out. A group that becomes acceptable only because of this cycle's drain is not accepted this cycle.
- trap_valid rises the cycle after the edge at which the trap entry drains and stays high. cycle_cnt stops incrementing once trap_valid=1.
- cycle_cnt increments every cycle while trap_valid=0.
- instr_cnt += n_out each cycle.
- Full: count==DEPTH forces in_ready=0. Empty: count==0 forces out_valid=0.
- Overflow: in_valid lanes offered with in_ready=0 are dropped and overflow_err is set. Intake continues normally on later cycles.

Decomposition:
- defines.v gains: COMMIT_W_DEF, TRAP_OPCODE (7'h6b), and the commit-record field widths and packing order {skip, wen, wdest, wdata, inst, pc}.
- Sub-module commit_fifo: multi-write/multi-read circular buffer parametrised by DEPTH, COMMIT_W and record width. It exposes count, per-lane head records, push count and pop count.
- commit_tracker top contains trap detection, the counters and in_ready.

Test Plan:
- Reset then idle for 10 cycles with out_ready=1 -> out_valid=0, in_ready=1, cycle_cnt=10, instr_cnt=0.
- Two lanes valid every cycle, out_ready=1, DEPTH=8 -> each group appears on out lanes 0/1 one cycle later in order; instr_cnt increments by 2 per cycle.
- out_ready=0, 2-lane groups pushed -> in_ready drops after the 4th group (count=8). Raise out_ready -> drains two entries per cycle; PC order preserved across the pointer wrap.
- Lane 0 = addi, lane 1 = trap (0x0000006b) with in_a0=0 -> both enqueued, in_ready=0 next cycle, trap_code=0x00, trap_valid=1 the cycle after the trap entry drains, cycle_cnt frozen.
- Lane 0 = trap, lane 1 = addi, in_a0=0x5 -> only lane 0 enqueued, instr_cnt ends at 1, trap_code=0x05.
- Push with in_ready=0 -> overflow_err=1 and the data is absent from the output stream. Assert reset mid-drain -> count=0 and out_valid=0 immediately (asynchronous).
